// File: rtl/board_pkg.sv
// Shared board geometry, scan state encoding and row helpers for the LED matrix scanner.
package board_pkg;
  localparam int BOARD_W = 32;
  localparam int ROWS    = 8;
  localparam int COLS    = 4;
  localparam int ROW_W   = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  function automatic logic [COLS-1:0] row_slice(input logic [BOARD_W-1:0] board,
                                                input logic [ROW_W-1:0]   row);
    return board[row*COLS +: COLS];
  endfunction

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
    logic [ROWS-1:0] v;
    v = '0;
    v[row] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/board_scan_row_timer.sv
// Dwell/blank down-counter: phase_end on the last cycle of a SHOW or GAP phase,
// row_end on the last cycle of a whole row slot; strobes are combinational, no backpressure.
module row_timer #(
  parameter int DWELL = 16,
  parameter int BLANK = 1
) (
  input  logic clka,
  input  logic restart,
  input  logic run,
  input  logic in_gap,
  output logic phase_end,
  output logic row_end
);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

  logic [CW-1:0] cnt;

  assign phase_end = run && (cnt == '0);
  // With no blank phase the dwell phase itself closes the row slot.
  assign row_end   = phase_end && (in_gap || (BLANK == 0));

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= DWELL_LD;
    end else if (phase_end) begin
      cnt <= (!in_gap && (BLANK > 0)) ? BLANK_LD : DWELL_LD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/board_scan.sv
// Double-buffered LED matrix row scanner; first row appears two edges after the first load,
// loads are never refused (last one per frame wins). Optional flash on game-over: BOARD_SCAN_FLASH_EN.
module board_scan
  import board_pkg::*;
#(
  parameter int DWELL = 16,
  parameter int BLANK = 1
) (
  input  logic               clka,
  input  logic               restart,
  input  logic [BOARD_W-1:0] board_in,
  input  logic               load,
  input  logic               error,
  output logic [ROWS-1:0]    row_sel,
  output logic [COLS-1:0]    col_data,
  output logic               frame_done
);
  scan_state_t        state;
  logic [BOARD_W-1:0] active;
  logic [BOARD_W-1:0] pending;
  logic               pending_valid;
  logic [ROW_W-1:0]   row;
  logic               frame_tog;
  logic               phase_end;
  logic               row_end;
  logic               wrap;
  logic               blank_cols;

  assign wrap = row_end && (row == ROW_W'(ROWS - 1));

  row_timer #(
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) u_row_timer (
    .clka      (clka),
    .restart   (restart),
    .run       (state != IDLE),
    .in_gap    (state == GAP),
    .phase_end (phase_end),
    .row_end   (row_end)
  );

`ifdef BOARD_SCAN_FLASH_EN
  logic flash;

  // Game-over is only looked at on frame boundaries so a frame is never half-flashed.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      flash <= 1'b0;
    end else if (wrap) begin
      flash <= error;
    end
  end

  assign blank_cols = flash && frame_tog;
`else
  logic unused_error;
  assign unused_error = error;
  assign blank_cols   = 1'b0;
`endif

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state         <= IDLE;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      row           <= '0;
      frame_tog     <= 1'b0;
      row_sel       <= '0;
      col_data      <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= wrap;
      row_sel    <= (state == SHOW) ? row_onehot(row) : '0;
      col_data   <= ((state == SHOW) && !blank_cols) ? row_slice(active, row) : '0;

      case (state)
        IDLE: begin
          if (load) begin
            active <= board_in;
            row    <= '0;
            state  <= SHOW;
          end
        end
        default: begin
          if (row_end) begin
            state <= SHOW;
            row   <= wrap ? '0 : row + 1'b1;
          end else if (phase_end) begin
            state <= GAP;
          end

          if (load) begin
            pending       <= board_in;
            pending_valid <= 1'b1;
          end

          // The old pending board swaps in even when a new one lands on this same edge.
          if (wrap) begin
            frame_tog <= ~frame_tog;
            if (pending_valid) begin
              active <= pending;
              if (!load) begin
                pending_valid <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end
endmodule
